acc_alu_seq: RTL and testbench

- Parametrised accumulator ALU.
- Holds an internal WIDTH-bit accumulator and a registered flag set.
- Accepts one operation per valid/ready handshake. Single-cycle ops complete in one clock; MUL is a multi-cycle shift-add taking WIDTH clocks.
- Sits between the register/memory operand path and the shared data bus. It is the next generation of the 4-bit add/and/or/xor accumulator unit, adding SUB, SHL, MUL, an overflow flag and a handshake.

---
 rtl/acc_alu_pkg.sv | 32 +++
 rtl/acc_alu_seq_mul.sv | 78 +++++++
 rtl/acc_alu_seq.sv | 178 +++++++++++++++++
 tb/tb_acc_alu_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_alu_pkg.sv
// ---------------------------------------------------------------------------
// acc_alu_pkg
// Shared definitions for the accumulator ALU:
//   - opcode constants OP_ADD..OP_MUL (3-bit op_code encoding)
//   - flag bit indices inside the 4-bit {V,N,Z,C} flag word
//   - FSM state encoding (IDLE / MUL)
//   - flag word value after reset (only Z set, accumulator is zero)
// ---------------------------------------------------------------------------
package acc_alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 2;
   localparam int FLG_V = 3;

   localparam logic [3:0] FLAGS_RESET = 4'b0010;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/acc_alu_seq_mul.sv
// ---------------------------------------------------------------------------
// seq_mul
// Unsigned shift-add multiplier, one partial product per clock, WIDTH clocks
// per multiplication.
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset; discards any partial product
//   start    begin a multiplication (ignored while busy)
//   mcand    multiplicand, latched on start
//   mplier   multiplier, latched on start
//   busy     a multiplication is in progress
//   done     combinational: the current clock edge writes the last partial
//            product, so product is final in this cycle
//   product  2*WIDTH-bit running product including this cycle's addition
// ---------------------------------------------------------------------------
module seq_mul
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] product_reg;
   logic [2*WIDTH-1:0] product_next;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               busy_reg;

   // The multiplicand shifts left and the multiplier shifts right each
   // cycle, so the current multiplier bit is always mplier_reg[0].
   always_comb begin
      product_next = product_reg;
      if (mplier_reg[0]) begin
         product_next = product_reg + mcand_reg;
      end
   end

   // Last iteration: the caller samples product (== product_next) on the
   // same edge that retires the multiplication.
   assign done    = busy_reg && (count_reg == CNT_W'(WIDTH - 1));
   assign busy    = busy_reg;
   assign product = product_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         product_reg <= '0;
         count_reg   <= '0;
         busy_reg    <= 1'b0;
      end else if (start && !busy_reg) begin
         mcand_reg   <= {{WIDTH{1'b0}}, mcand};
         mplier_reg  <= mplier;
         product_reg <= '0;
         count_reg   <= '0;
         busy_reg    <= 1'b1;
      end else if (busy_reg) begin
         product_reg <= product_next;
         mcand_reg   <= mcand_reg << 1;
         mplier_reg  <= mplier_reg >> 1;
         count_reg   <= count_reg + CNT_W'(1);
         if (done) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/acc_alu_seq.sv
// ---------------------------------------------------------------------------
// acc_alu_seq
// Accumulator ALU with valid/ready handshake. Single-cycle ops (ADD, AND, OR,
// XOR, SUB, LOAD, SHL) write acc/flags on the accepting edge; MUL runs in the
// seq_mul sub-block for WIDTH clocks while op_ready is low.
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   op_valid  operation request
//   op_ready  operation can be accepted this cycle (combinational from state)
//   op_code   operation select (see acc_alu_pkg)
//   tmp_in    second operand
//   din       LOAD data
//   out_sel   1: drive acc onto bus_out, 0: bus_out = 0
//   bus_out   bus data
//   acc_out   accumulator
//   flags     registered {V,N,Z,C}
//   done      one-cycle pulse after a result is written
// ---------------------------------------------------------------------------
module acc_alu_seq
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] tmp_in,
   input  logic [WIDTH-1:0] din,
   input  logic             out_sel,
   output logic [WIDTH-1:0] bus_out,
   output logic [WIDTH-1:0] acc_out,
   output logic [3:0]       flags,
   output logic             done
);

   state_t               state_reg;
   state_t               state_next;
   logic [WIDTH-1:0]     acc_reg;
   logic [3:0]           flags_reg;
   logic                 done_reg;

   logic                 accept;
   logic                 mul_start;
   logic                 mul_busy;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;
   logic [3:0]           mul_flags;

   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       diff_ext;
   logic [WIDTH-1:0]     alu_res;
   logic [3:0]           alu_flags;
   logic                 alu_c;
   logic                 alu_v;

   assign op_ready  = (state_reg == ST_IDLE);
   assign accept    = op_valid && op_ready;
   assign mul_start = accept && (op_code == OP_MUL);

   // Extra top bit holds the carry (ADD) or the borrow (SUB).
   assign sum_ext  = {1'b0, acc_reg} + {1'b0, tmp_in};
   assign diff_ext = {1'b0, acc_reg} - {1'b0, tmp_in};

   always_comb begin
      alu_res = acc_reg;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_code)
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            // Same-sign operands producing an opposite-sign result.
            alu_v   = (acc_reg[WIDTH-1] == tmp_in[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != acc_reg[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];
            // Opposite-sign operands and result sign differs from minuend.
            alu_v   = (acc_reg[WIDTH-1] != tmp_in[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != acc_reg[WIDTH-1]);
         end
         OP_AND:  alu_res = acc_reg & tmp_in;
         OP_OR:   alu_res = acc_reg | tmp_in;
         OP_XOR:  alu_res = acc_reg ^ tmp_in;
         OP_LOAD: alu_res = din;
         OP_SHL: begin
            alu_res = {acc_reg[WIDTH-2:0], 1'b0};
            alu_c   = acc_reg[WIDTH-1];
         end
         default: alu_res = acc_reg;
      endcase
      alu_flags        = '0;
      alu_flags[FLG_C] = alu_c;
      alu_flags[FLG_Z] = (alu_res == '0);
      alu_flags[FLG_N] = alu_res[WIDTH-1];
      alu_flags[FLG_V] = alu_v;
   end

   // MUL result flags: C reports truncation of the high half.
   always_comb begin
      mul_flags        = '0;
      mul_flags[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
      mul_flags[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
      mul_flags[FLG_N] = mul_product[WIDTH-1];
   end

   seq_mul #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .mcand   (acc_reg),
      .mplier  (tmp_in),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (mul_start) begin
               state_next = ST_MUL;
            end
         end
         ST_MUL: begin
            // An idle multiplier here can only mean it was never started;
            // fall back to IDLE rather than stall the handshake.
            if (mul_done || !mul_busy) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         flags_reg <= FLAGS_RESET;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         if (accept && (op_code != OP_MUL)) begin
            acc_reg   <= alu_res;
            flags_reg <= alu_flags;
            done_reg  <= 1'b1;
         end else if (mul_done) begin
            acc_reg   <= mul_product[WIDTH-1:0];
            flags_reg <= mul_flags;
            done_reg  <= 1'b1;
         end
      end
   end

   // Bus gating: the block drives zeros when not selected.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bus
         assign bus_out[gi] = out_sel & acc_reg[gi];
      end
   endgenerate

   assign acc_out = acc_reg;
   assign flags   = flags_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_acc_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_acc_alu_seq
// Directed test of acc_alu_seq (WIDTH=4) against a behavioural model that
// computes results with integer arithmetic, plus literal expectations.
// ---------------------------------------------------------------------------
module tb_acc_alu_seq;
   import acc_alu_pkg::*;

   localparam int W = 4;
   localparam int M = 1 << W;
   localparam int H = M / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         op_valid;
   logic         op_ready;
   logic [2:0]   op_code;
   logic [W-1:0] tmp_in;
   logic [W-1:0] din;
   logic         out_sel;
   logic [W-1:0] bus_out;
   logic [W-1:0] acc_out;
   logic [3:0]   flags;
   logic         done;

   int checks = 0;
   int errors = 0;

   acc_alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .tmp_in   (tmp_in),
      .din      (din),
      .out_sel  (out_sel),
      .bus_out  (bus_out),
      .acc_out  (acc_out),
      .flags    (flags),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       exp_acc   = 0;
   logic [3:0] exp_flags = 4'b0010;
   bit       exp_done  = 0;
   int       mul_left  = 0;
   int       mul_prod  = 0;
   bit       started   = 0;

   function automatic int sgn(input int x);
      return (x >= H) ? x - M : x;
   endfunction

   function automatic logic [3:0] mk_flags(input int r, input bit c, input bit v);
      return {v, (r >= H), (r == 0), c};
   endfunction

   always @(posedge clk) begin
      int a, b, r, s;
      bit c, v;
      if (!rst_n) begin
         exp_acc   = 0;
         exp_flags = 4'b0010;
         exp_done  = 0;
         mul_left  = 0;
         started   = 1;
      end else begin
         exp_done = 0;
         if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
               exp_acc   = mul_prod % M;
               exp_flags = mk_flags(exp_acc, (mul_prod >= M), 0);
               exp_done  = 1;
            end
         end else if (op_valid) begin
            a = exp_acc;
            b = int'(tmp_in);
            c = 0;
            v = 0;
            r = a;
            case (op_code)
               OP_ADD: begin
                  r = (a + b) % M;
                  c = (a + b) >= M;
                  s = sgn(a) + sgn(b);
                  v = (s > H - 1) || (s < -H);
               end
               OP_SUB: begin
                  r = (a - b + M) % M;
                  c = a < b;
                  s = sgn(a) - sgn(b);
                  v = (s > H - 1) || (s < -H);
               end
               OP_AND:  r = int'(W'(a) & tmp_in);
               OP_OR:   r = int'(W'(a) | tmp_in);
               OP_XOR:  r = int'(W'(a) ^ tmp_in);
               OP_LOAD: r = int'(din);
               OP_SHL: begin
                  r = (a * 2) % M;
                  c = a >= H;
               end
               default: begin
                  mul_prod = a * b;
                  mul_left = W;
               end
            endcase
            if (op_code != OP_MUL) begin
               exp_acc   = r;
               exp_flags = mk_flags(r, c, v);
               exp_done  = 1;
            end
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("cyc_acc",   int'(acc_out),  exp_acc);
         chk("cyc_flags", int'(flags),    int'(exp_flags));
         chk("cyc_done",  int'(done),     int'(exp_done));
         chk("cyc_ready", int'(op_ready), (mul_left == 0) ? 1 : 0);
         chk("cyc_bus",   int'(bus_out),  out_sel ? exp_acc : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic op1(input logic [2:0] c, input logic [W-1:0] t, input logic [W-1:0] d);
      op_valid = 1'b1;
      op_code  = c;
      tmp_in   = t;
      din      = d;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!op_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ready_timeout", (n < 50) ? 1 : 0, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op_code  = OP_ADD;
      tmp_in   = '0;
      din      = '0;
      out_sel  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_acc", int'(acc_out), 0);
      chk("rst_flags", int'(flags), 4'b0010);
      chk("rst_ready", int'(op_ready), 1);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // LOAD then ADD back to back
      op1(OP_LOAD, 4'd0, 4'b0010);
      chk("load_acc", int'(acc_out), 2);
      chk("load_done", int'(done), 1);
      op1(OP_ADD, 4'b0001, 4'd0);
      chk("add1_acc", int'(acc_out), 3);
      chk("add1_flags", int'(flags), 4'b0000);
      chk("add1_done", int'(done), 1);
      chk("add1_ready", int'(op_ready), 1);
      chk("model_add1", exp_acc, 3);

      // signed overflow, then AND clears V
      op1(OP_ADD, 4'b0111, 4'd0);
      chk("add2_acc", int'(acc_out), 4'b1010);
      chk("add2_flags", int'(flags), 4'b1100);
      op1(OP_AND, 4'b1110, 4'd0);
      chk("and_acc", int'(acc_out), 4'b1010);
      chk("and_flags", int'(flags), 4'b0100);
      chk("model_and", int'(exp_flags), 4'b0100);

      // SUB with borrow, SUB to zero
      op1(OP_LOAD, 4'd0, 4'b0010);
      op1(OP_SUB, 4'b0011, 4'd0);
      chk("sub1_acc", int'(acc_out), 4'b1111);
      chk("sub1_flags", int'(flags), 4'b0101);
      op1(OP_SUB, 4'b1111, 4'd0);
      chk("sub2_acc", int'(acc_out), 0);
      chk("sub2_flags", int'(flags), 4'b0010);

      // MUL 5*3 with op_valid held high during busy
      op1(OP_LOAD, 4'd0, 4'b0101);
      op_valid = 1'b1;
      op_code  = OP_MUL;
      tmp_in   = 4'b0011;
      @(posedge clk);
      #1;
      op_code = OP_ADD;
      tmp_in  = 4'b0001;
      for (int i = 0; i < W; i++) begin
         chk("mul_busy_ready", int'(op_ready), 0);
         chk("mul_hold_acc", int'(acc_out), 5);
         @(posedge clk);
         #1;
      end
      chk("mul1_ready", int'(op_ready), 1);
      chk("mul1_acc", int'(acc_out), 4'b1111);
      chk("mul1_flags", int'(flags), 4'b0100);
      chk("mul1_done", int'(done), 1);
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mul1_done_once", int'(done), 0);

      // MUL 6*5 = 30 -> low 1110, high nonzero
      op1(OP_LOAD, 4'd0, 4'b0110);
      op1(OP_MUL, 4'b0101, 4'd0);
      wait_ready();
      chk("mul2_acc", int'(acc_out), 4'b1110);
      chk("mul2_flags", int'(flags), 4'b0101);

      // reset in the middle of a MUL
      op1(OP_LOAD, 4'd0, 4'b0101);
      op1(OP_MUL, 4'b0011, 4'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_acc", int'(acc_out), 0);
      chk("mrst_flags", int'(flags), 4'b0010);
      chk("mrst_ready", int'(op_ready), 1);
      chk("mrst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(posedge clk);
         #1;
         chk("mrst_no_done", int'(done), 0);
      end

      // SHL, then bus gating
      op1(OP_LOAD, 4'd0, 4'b1001);
      op1(OP_SHL, 4'd0, 4'd0);
      chk("shl_acc", int'(acc_out), 4'b0010);
      chk("shl_flags", int'(flags), 4'b0001);
      for (int i = 0; i < 4; i++) begin
         out_sel = (i % 2) == 1;
         #2;
         chk("bus_gate", int'(bus_out), ((i % 2) == 1) ? 2 : 0);
         chk("bus_acc_hold", int'(acc_out), 2);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
